// File: rtl/kanade_pipe_ctrl.sv
// kanade_pipe_ctrl: PC, stage-register, RAM-port and register-file enable sequencer for the KANADE32 pipeline.
// Latency: every control output is combinational from registered state plus same-cycle inputs; state moves on clk.
// Backpressure: RAW hazards and data-memory cycles hold fetch (pc_wren / stage_wren[0] low); redirect overrides both.
module kanade_pipe_ctrl #(
  parameter int STAGES         = 4,
  parameter int MODE           = 1,
  parameter int REDIRECT_STAGE = STAGES - 2,
  parameter int REG_AW         = 5,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic              dec_uses_rs,
  input  logic              dec_uses_rt,
  input  logic [REG_AW-1:0] dec_dst_reg,
  input  logic              dec_reg_write,
  input  logic              mem_access,
  input  logic              wb_reg_write,
  input  logic              redirect,
  output logic              pc_wren,
  output logic              pc_redirect,
  output logic [STAGES-1:0] stage_wren,
  output logic [STAGES-1:0] stage_valid,
  output logic              ram_addr_src,
  output logic              mem_stage_en,
  output logic              reg_wren,
  output logic              stall,
  output logic [CNT_W-1:0]  instret,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int              PH_W    = $clog2(STAGES + 1);
  localparam logic [PH_W-1:0] PH_MEM  = PH_W'(STAGES - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STAGES);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [REG_AW-1:0] dst_q [1:STAGES-1];
  logic [STAGES-1:1] wr_q;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  instret_q, stall_cnt_q;
  logic              hit_rs, hit_rt;
  logic              hazard, memcyc, redir;
  logic              inc_instret, inc_stall;

  assign stage_valid = valid_q;
  assign instret     = instret_q;
  assign stall_cnt   = stall_cnt_q;

  // Scoreboard lookup: any live downstream writer of a stage-0 source, write-back stage included (no forwarding).
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      if (valid_q[i] && wr_q[i]) begin
        if (dst_q[i] == dec_rs) hit_rs = 1'b1;
        if (dst_q[i] == dec_rt) hit_rt = 1'b1;
      end
    end
  end

  // Register 0 is hardwired, so it never creates a dependency.
  assign hazard = (MODE != 0) && valid_q[0] &&
                  ((dec_uses_rs && (dec_rs != '0) && hit_rs) ||
                   (dec_uses_rt && (dec_rt != '0) && hit_rt));
  assign memcyc = (MODE != 0) && valid_q[STAGES-2] && mem_access;
  assign redir  = (MODE != 0) && valid_q[REDIRECT_STAGE] && redirect;

  // Output decode and next-state: sequential phase walk, or pipelined redirect > hazard > memcyc > fetch.
  always_comb begin
    pc_wren      = 1'b0;
    pc_redirect  = 1'b0;
    stage_wren   = '0;
    ram_addr_src = 1'b0;
    mem_stage_en = 1'b0;
    reg_wren     = 1'b0;
    stall        = 1'b0;
    valid_d      = valid_q;
    phase_d      = phase_q;
    inc_instret  = 1'b0;
    inc_stall    = 1'b0;
    if (MODE == 0) begin
      if (phase_q == PH_LAST) begin
        pc_wren     = 1'b1;
        pc_redirect = redirect;
        reg_wren    = wb_reg_write;
        inc_instret = 1'b1;
        valid_d     = '0;
        phase_d     = '0;
      end else begin
        stage_wren = {{(STAGES-1){1'b0}}, 1'b1} << phase_q;
        valid_d    = valid_q | stage_wren;
        phase_d    = phase_q + PH_W'(1);
        if (phase_q == PH_MEM) begin
          ram_addr_src = 1'b1;
          mem_stage_en = 1'b1;
        end
      end
    end else begin
      stage_wren                = '1;
      valid_d[STAGES-1:1]       = valid_q[STAGES-2:0];
      ram_addr_src              = memcyc;
      mem_stage_en              = memcyc;
      reg_wren                  = valid_q[STAGES-1] && wb_reg_write;
      inc_instret               = valid_q[STAGES-1];
      if (redir) begin
        // Wrong-path work up to the resolving stage is squashed, including this cycle's fetch.
        pc_wren       = 1'b1;
        pc_redirect   = 1'b1;
        stage_wren[0] = !memcyc;
        for (int i = 0; i <= REDIRECT_STAGE; i++) valid_d[i] = 1'b0;
      end else if (hazard) begin
        stall         = 1'b1;
        stage_wren[0] = 1'b0;
        valid_d[0]    = valid_q[0];
        valid_d[1]    = 1'b0;
        inc_stall     = 1'b1;
      end else if (memcyc) begin
        // The single RAM port serves data this cycle, so nothing is fetched.
        stage_wren[0] = 1'b0;
        valid_d[0]    = 1'b0;
        inc_stall     = 1'b1;
      end else begin
        pc_wren       = 1'b1;
        stage_wren[0] = 1'b1;
        valid_d[0]    = 1'b1;
      end
    end
  end

  // State register: valid bits, phase, counters and the destination scoreboard that shifts with the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      phase_q     <= '0;
      instret_q   <= '0;
      stall_cnt_q <= '0;
      wr_q        <= '0;
      for (int i = 1; i < STAGES; i++) dst_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      phase_q  <= phase_d;
      if (inc_instret) instret_q   <= instret_q + CNT_W'(1);
      if (inc_stall)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      dst_q[1] <= dec_dst_reg;
      wr_q[1]  <= dec_reg_write;
      for (int i = 2; i < STAGES; i++) begin
        dst_q[i] <= dst_q[i-1];
        wr_q[i]  <= wr_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_kanade_pipe_ctrl.sv
// tb_kanade_pipe_ctrl: directed checks of kanade_pipe_ctrl in sequential (MODE 0) and pipelined (MODE 1) form.
// Latency: outputs sampled 1 ns after each falling edge, inputs driven on the falling edge.
// Backpressure: none; every step runs a fixed number of cycles.
module tb_kanade_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] dec_rs, dec_rt, dec_dst_reg;
  logic       dec_uses_rs, dec_uses_rt, dec_reg_write;
  logic       mem_access, wb_reg_write, redirect;

  logic        m0_pc_wren, m0_pc_redirect, m0_ram_addr_src, m0_mem_stage_en, m0_reg_wren, m0_stall;
  logic [3:0]  m0_stage_wren, m0_stage_valid;
  logic [31:0] m0_instret, m0_stall_cnt;
  logic        m1_pc_wren, m1_pc_redirect, m1_ram_addr_src, m1_mem_stage_en, m1_reg_wren, m1_stall;
  logic [3:0]  m1_stage_wren, m1_stage_valid;
  logic [31:0] m1_instret, m1_stall_cnt;

  int          n_cmp  = 0;
  int          n_fail = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  kanade_pipe_ctrl #(.STAGES(4), .MODE(0)) u_seq (
    .clk(clk), .reset_n(reset_n),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_dst_reg(dec_dst_reg), .dec_reg_write(dec_reg_write),
    .mem_access(mem_access), .wb_reg_write(wb_reg_write), .redirect(redirect),
    .pc_wren(m0_pc_wren), .pc_redirect(m0_pc_redirect), .stage_wren(m0_stage_wren),
    .stage_valid(m0_stage_valid), .ram_addr_src(m0_ram_addr_src), .mem_stage_en(m0_mem_stage_en),
    .reg_wren(m0_reg_wren), .stall(m0_stall), .instret(m0_instret), .stall_cnt(m0_stall_cnt)
  );

  kanade_pipe_ctrl #(.STAGES(4), .MODE(1)) u_pipe (
    .clk(clk), .reset_n(reset_n),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_dst_reg(dec_dst_reg), .dec_reg_write(dec_reg_write),
    .mem_access(mem_access), .wb_reg_write(wb_reg_write), .redirect(redirect),
    .pc_wren(m1_pc_wren), .pc_redirect(m1_pc_redirect), .stage_wren(m1_stage_wren),
    .stage_valid(m1_stage_valid), .ram_addr_src(m1_ram_addr_src), .mem_stage_en(m1_mem_stage_en),
    .reg_wren(m1_reg_wren), .stall(m1_stall), .instret(m1_instret), .stall_cnt(m1_stall_cnt)
  );

  task automatic expect_v(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h with no expected value queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic set_dec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic urs, input logic urt, input logic wr);
    dec_rs = rs; dec_rt = rt; dec_dst_reg = dst;
    dec_uses_rs = urs; dec_uses_rt = urt; dec_reg_write = wr;
  endtask

  // Holds reset across two edges and releases on a falling edge: the caller then stands at cycle 0.
  task automatic apply_reset();
    mem_access = 1'b0;
    redirect   = 1'b0;
    set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One pipelined-mode cycle: queue every control output, let inputs settle, compare in the same order.
  task automatic cyc_m1(input string t, input logic pc, input logic rd, input logic [3:0] sw,
                        input logic [3:0] vl, input logic st, input logic mc);
    expect_v({t, ".pc_wren"},      64'(pc));
    expect_v({t, ".pc_redirect"},  64'(rd));
    expect_v({t, ".stage_wren"},   64'(sw));
    expect_v({t, ".stage_valid"},  64'(vl));
    expect_v({t, ".stall"},        64'(st));
    expect_v({t, ".ram_addr_src"}, 64'(mc));
    expect_v({t, ".mem_stage_en"}, 64'(mc));
    expect_v({t, ".reg_wren"},     64'(vl[3] & wb_reg_write));
    #1;
    check_v(64'(m1_pc_wren));
    check_v(64'(m1_pc_redirect));
    check_v(64'(m1_stage_wren));
    check_v(64'(m1_stage_valid));
    check_v(64'(m1_stall));
    check_v(64'(m1_ram_addr_src));
    check_v(64'(m1_mem_stage_en));
    check_v(64'(m1_reg_wren));
  endtask

  // add r3 (or r0) followed directly by sub r4,r3,r1, then independent filler.
  task automatic run_raw(input logic [4:0] add_dst);
    logic [3:0] v [0:6];
    logic [6:0] s;
    apply_reset();
    if (add_dst == 5'd0) begin
      v = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF};
      s = 7'b0000000;
    end else begin
      v = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h9, 4'h1, 4'h3};
      s = 7'b0011100;
    end
    for (int c = 0; c < 7; c++) begin
      if (c == 1)               set_dec(5'd1, 5'd2, add_dst, 1'b1, 1'b1, 1'b1);
      else if (c >= 2 && c <= 5) set_dec(5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1);
      else                      set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc_m1($sformatf("raw_r%0d_c%0d", add_dst, c), !s[c], 1'b0, s[c] ? 4'hE : 4'hF, v[c], s[c], 1'b0);
      if (c == 6) begin
        expect_v($sformatf("raw_r%0d.stall_cnt", add_dst), (add_dst == 5'd0) ? 64'd0 : 64'd3);
        check_v(64'(m1_stall_cnt));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] fill_v [0:4];
    logic [3:0] rd_v   [0:5];
    logic [5:0] rd_st, rd_pc;
    wb_reg_write = 1'b1;
    apply_reset();

    // Sequential mode: phases 0..4 repeat, three instructions in 15 cycles; a redirect rides on the second PC load.
    for (int c = 0; c < 15; c++) begin
      int p;
      p = c % 5;
      redirect = (c == 9);
      expect_v($sformatf("seq_c%0d.pc_wren", c),      64'(p == 4));
      expect_v($sformatf("seq_c%0d.pc_redirect", c),  64'(p == 4 && c == 9));
      expect_v($sformatf("seq_c%0d.stage_wren", c),   (p < 4) ? (64'd1 << p) : 64'd0);
      expect_v($sformatf("seq_c%0d.stage_valid", c),  (64'd1 << p) - 64'd1);
      expect_v($sformatf("seq_c%0d.ram_addr_src", c), 64'(p == 3));
      expect_v($sformatf("seq_c%0d.mem_stage_en", c), 64'(p == 3));
      expect_v($sformatf("seq_c%0d.reg_wren", c),     64'(p == 4));
      expect_v($sformatf("seq_c%0d.stall", c),        64'd0);
      if (c == 0) expect_v("seq_reset.instret", 64'd0);
      #1;
      check_v(64'(m0_pc_wren));
      check_v(64'(m0_pc_redirect));
      check_v(64'(m0_stage_wren));
      check_v(64'(m0_stage_valid));
      check_v(64'(m0_ram_addr_src));
      check_v(64'(m0_mem_stage_en));
      check_v(64'(m0_reg_wren));
      check_v(64'(m0_stall));
      if (c == 0) check_v(64'(m0_instret));
      @(negedge clk);
    end
    redirect = 1'b0;
    expect_v("seq.instret", 64'd3);
    expect_v("seq.stall_cnt", 64'd0);
    #1;
    check_v(64'(m0_instret));
    check_v(64'(m0_stall_cnt));

    // Pipelined: independent ALU stream (reads r1/r2, writes r10 upward).
    apply_reset();
    for (int c = 0; c <= 12; c++) begin
      set_dec(5'd1, 5'd2, 5'(10 + c), 1'b1, 1'b1, 1'b1);
      cyc_m1($sformatf("alu_c%0d", c), 1'b1, 1'b0, 4'hF, (c >= 4) ? 4'hF : 4'((1 << c) - 1), 1'b0, 1'b0);
      if (c == 0) begin
        expect_v("alu_reset.instret", 64'd0);
        check_v(64'(m1_instret));
      end
      if (c == 12) begin
        expect_v("alu.instret", 64'd8);
        expect_v("alu.stall_cnt", 64'd0);
        check_v(64'(m1_instret));
        check_v(64'(m1_stall_cnt));
      end
      @(negedge clk);
    end

    run_raw(5'd3);
    run_raw(5'd0);

    // Pipelined: load reaches stage 2 in cycle 3 and takes the RAM port.
    apply_reset();
    fill_v = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE};
    for (int c = 0; c < 5; c++) begin
      mem_access = (c == 3);
      cyc_m1($sformatf("ld_c%0d", c), c != 3, 1'b0, (c == 3) ? 4'hE : 4'hF, fill_v[c], 1'b0, c == 3);
      if (c >= 3) begin
        expect_v($sformatf("ld_c%0d.stall_cnt", c), (c == 3) ? 64'd0 : 64'd1);
        check_v(64'(m1_stall_cnt));
      end
      @(negedge clk);
    end
    mem_access = 1'b0;

    // Pipelined: r5 producer, r5 consumer stalls, then the producer in stage 2 is a taken branch.
    apply_reset();
    rd_v  = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h8, 4'h1};
    rd_st = 6'b000100;
    rd_pc = 6'b111011;
    for (int c = 0; c < 6; c++) begin
      if (c == 1)               set_dec(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
      else if (c >= 2 && c <= 4) set_dec(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
      else                      set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      redirect = (c == 3);
      cyc_m1($sformatf("br_c%0d", c), rd_pc[c], c == 3, rd_st[c] ? 4'hE : 4'hF, rd_v[c], rd_st[c], 1'b0);
      if (c >= 4) begin
        expect_v($sformatf("br_c%0d.stall_cnt", c), 64'd1);
        check_v(64'(m1_stall_cnt));
      end
      @(negedge clk);
    end
    redirect = 1'b0;

    // Reset pulled mid-cycle with a full pipe: state clears without any clock edge.
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      cyc_m1($sformatf("rst_c%0d", c), 1'b1, 1'b0, 4'hF, (c >= 4) ? 4'hF : 4'((1 << c) - 1), 1'b0, 1'b0);
      @(negedge clk);
    end
    expect_v("rst_pre.instret", 64'd1);
    #1;
    check_v(64'(m1_instret));
    #1;
    reset_n = 1'b0;
    expect_v("rst_async.stage_valid", 64'd0);
    expect_v("rst_async.instret",     64'd0);
    expect_v("rst_async.stall_cnt",   64'd0);
    expect_v("rst_async.pc_wren",     64'd1);
    expect_v("rst_async.seq_valid",   64'd0);
    expect_v("rst_async.seq_instret", 64'd0);
    #1;
    check_v(64'(m1_stage_valid));
    check_v(64'(m1_instret));
    check_v(64'(m1_stall_cnt));
    check_v(64'(m1_pc_wren));
    check_v(64'(m0_stage_valid));
    check_v(64'(m0_instret));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc_m1("rst_rel_c0", 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    cyc_m1("rst_rel_c1", 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
